// File: rtl/score_disp_pkg.sv
// Shared constants, FSM state type and the double-dabble adjust step for the
// score display controller.
package score_disp_pkg;

  // Active-low segment codes, bit order gfedcba.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
    logic [11:0] res;
    res = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/score_display_ctrl_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder with a blank
// override; codes 10..15 also show blank.
module bcd_to_seg7
  import score_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Two-channel score converter: round-robin arbitration onto one sequential
// double-dabble engine, results latched per channel as BCD and segment codes.
module score_display_ctrl
  import score_disp_pkg::*;
#(
  parameter int SAT_VAL  = 999,
  parameter int BIN_W    = 10,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [15:0] val_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [15:0] val_b,
  output logic        ack_b,
  output logic        busy,
  output logic        done,
  output logic        done_ch,
  output logic [11:0] bcd_a,
  output logic [11:0] bcd_b,
  output logic        sat_a,
  output logic        sat_b,
  output logic [6:0]  seg_a_h,
  output logic [6:0]  seg_a_t,
  output logic [6:0]  seg_a_o,
  output logic [6:0]  seg_b_h,
  output logic [6:0]  seg_b_t,
  output logic [6:0]  seg_b_o
);

  // Handshake: req_x is a level held with a stable val_x until ack_x; ack_x is
  // a one-cycle pulse in the cycle after the capture edge. A req_x still high
  // when the engine next returns to IDLE counts as a new request.

  localparam int               CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [15:0]      SAT16    = 16'(SAT_VAL);

  state_t           state;
  state_t           state_next;
  logic [BIN_W-1:0] shift_reg;
  logic [11:0]      bcd_acc;
  logic [11:0]      bcd_adj;
  logic [CNT_W-1:0] cnt;
  logic             cur_ch;
  logic             cur_sat;
  logic             rr_ptr;
  logic             grant;
  logic             grant_ch;
  logic [15:0]      val_sel;
  logic             val_over;
  logic [BIN_W-1:0] val_cap;
  logic             blank_h;
  logic             blank_t;
  logic [6:0]       dec_h;
  logic [6:0]       dec_t;
  logic [6:0]       dec_o;

  assign busy     = (state != ST_IDLE);
  assign val_sel  = (grant_ch == CH_B) ? val_b : val_a;
  assign val_over = (val_sel > SAT16);
  assign val_cap  = val_over ? SAT16[BIN_W-1:0] : val_sel[BIN_W-1:0];
  assign bcd_adj  = dd_adjust(bcd_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // rr_ptr names the channel that wins when both requesters are waiting.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_ch   = CH_A;
    case (state)
      ST_IDLE: begin
        if (req_a || req_b) begin
          grant      = 1'b1;
          state_next = ST_SHIFT;
          if (req_a && req_b) begin
            grant_ch = rr_ptr;
          end else begin
            grant_ch = req_b ? CH_B : CH_A;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt == CNT_LAST) begin
          state_next = ST_UPDATE;
        end
      end
      ST_UPDATE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bcd_acc   <= '0;
      cnt       <= '0;
      cur_ch    <= CH_A;
      cur_sat   <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
    end else begin
      ack_a <= grant && (grant_ch == CH_A);
      ack_b <= grant && (grant_ch == CH_B);
      if (grant) begin
        shift_reg <= val_cap;
        bcd_acc   <= '0;
        cnt       <= '0;
        cur_ch    <= grant_ch;
        cur_sat   <= val_over;
      end else if (state == ST_SHIFT) begin
        bcd_acc   <= {bcd_adj[10:0], shift_reg[BIN_W-1]};
        shift_reg <= shift_reg << 1;
        cnt       <= cnt + 1'b1;
      end
    end
  end

  // Leading-zero blanking only affects the segment codes, never the BCD.
  assign blank_h = BLANK_LZ && (bcd_acc[11:8] == 4'd0);
  assign blank_t = blank_h && (bcd_acc[7:4] == 4'd0);

  bcd_to_seg7 u_seg_h (.digit(bcd_acc[11:8]), .blank(blank_h), .seg(dec_h));
  bcd_to_seg7 u_seg_t (.digit(bcd_acc[7:4]),  .blank(blank_t), .seg(dec_t));
  bcd_to_seg7 u_seg_o (.digit(bcd_acc[3:0]),  .blank(1'b0),    .seg(dec_o));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      done_ch <= CH_A;
      rr_ptr  <= CH_A;
      bcd_a   <= '0;
      bcd_b   <= '0;
      sat_a   <= 1'b0;
      sat_b   <= 1'b0;
      seg_a_h <= SEG_0;
      seg_a_t <= SEG_0;
      seg_a_o <= SEG_0;
      seg_b_h <= SEG_0;
      seg_b_t <= SEG_0;
      seg_b_o <= SEG_0;
    end else begin
      done <= 1'b0;
      if (state == ST_UPDATE) begin
        done    <= 1'b1;
        done_ch <= cur_ch;
        rr_ptr  <= ~cur_ch;
        if (cur_ch == CH_A) begin
          bcd_a   <= bcd_acc;
          sat_a   <= cur_sat;
          seg_a_h <= dec_h;
          seg_a_t <= dec_t;
          seg_a_o <= dec_o;
        end else begin
          bcd_b   <= bcd_acc;
          sat_b   <= cur_sat;
          seg_b_h <= dec_h;
          seg_b_t <= dec_t;
          seg_b_o <= dec_o;
        end
      end
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: one instance without and one with leading-zero
// blanking, a transaction-level reference model and a per-cycle comparator.
module tb_score_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b;
  logic [15:0] val_a, val_b;

  logic        n_ack_a, n_ack_b, n_busy, n_done, n_done_ch, n_sat_a, n_sat_b;
  logic [11:0] n_bcd_a, n_bcd_b;
  logic [6:0]  n_seg_a_h, n_seg_a_t, n_seg_a_o, n_seg_b_h, n_seg_b_t, n_seg_b_o;
  logic        b_ack_a, b_ack_b, b_busy, b_done, b_done_ch, b_sat_a, b_sat_b;
  logic [11:0] b_bcd_a, b_bcd_b;
  logic [6:0]  b_seg_a_h, b_seg_a_t, b_seg_a_o, b_seg_b_h, b_seg_b_t, b_seg_b_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  score_display_ctrl #(.SAT_VAL(999), .BIN_W(10), .BLANK_LZ(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .val_a(val_a), .ack_a(n_ack_a),
    .req_b(req_b), .val_b(val_b), .ack_b(n_ack_b),
    .busy(n_busy), .done(n_done), .done_ch(n_done_ch),
    .bcd_a(n_bcd_a), .bcd_b(n_bcd_b), .sat_a(n_sat_a), .sat_b(n_sat_b),
    .seg_a_h(n_seg_a_h), .seg_a_t(n_seg_a_t), .seg_a_o(n_seg_a_o),
    .seg_b_h(n_seg_b_h), .seg_b_t(n_seg_b_t), .seg_b_o(n_seg_b_o)
  );

  score_display_ctrl #(.SAT_VAL(999), .BIN_W(10), .BLANK_LZ(1'b1)) dut_bl (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .val_a(val_a), .ack_a(b_ack_a),
    .req_b(req_b), .val_b(val_b), .ack_b(b_ack_b),
    .busy(b_busy), .done(b_done), .done_ch(b_done_ch),
    .bcd_a(b_bcd_a), .bcd_b(b_bcd_b), .sat_a(b_sat_a), .sat_b(b_sat_b),
    .seg_a_h(b_seg_a_h), .seg_a_t(b_seg_a_t), .seg_a_o(b_seg_a_o),
    .seg_b_h(b_seg_b_h), .seg_b_t(b_seg_b_t), .seg_b_o(b_seg_b_o)
  );

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a request seen at edge n is captured if the engine is
  // free; its result appears 11 edges later; the next capture may follow on
  // the very next edge.
  int m_dig [2];
  bit m_sat [2];
  bit m_ptr, pend, p_ch;
  int p_val, done_at;
  bit e_ack_a, e_ack_b, e_done, e_done_ch, e_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dig[0] = 0; m_dig[1] = 0; m_sat[0] = 0; m_sat[1] = 0;
      m_ptr = 0; pend = 0; p_ch = 0; p_val = 0; done_at = 0;
      e_ack_a = 0; e_ack_b = 0; e_done = 0; e_done_ch = 0; e_busy = 0;
    end else begin
      e_ack_a = 0; e_ack_b = 0; e_done = 0;
      if (pend && cyc == done_at) begin
        m_dig[p_ch] = (p_val > 999) ? 999 : p_val;
        m_sat[p_ch] = (p_val > 999);
        e_done = 1; e_done_ch = p_ch; m_ptr = !p_ch;
        pend = 0; e_busy = 0;
      end else if (!pend && (req_a || req_b)) begin
        p_ch    = (req_a && req_b) ? m_ptr : req_b;
        p_val   = p_ch ? int'(val_b) : int'(val_a);
        pend    = 1; e_busy = 1;
        done_at = cyc + 11;
        if (p_ch) e_ack_b = 1; else e_ack_a = 1;
      end
    end
  end

  task automatic compare_all();
    int h [2], t [2], o [2];
    for (int c = 0; c < 2; c++) begin
      h[c] = m_dig[c] / 100; t[c] = (m_dig[c] / 10) % 10; o[c] = m_dig[c] % 10;
    end
    check("ack_a", n_ack_a, e_ack_a);
    check("ack_b", n_ack_b, e_ack_b);
    check("busy", n_busy, e_busy);
    check("done", n_done, e_done);
    check("done_ch", n_done_ch, e_done_ch);
    check("sat_a", n_sat_a, m_sat[0]);
    check("sat_b", n_sat_b, m_sat[1]);
    check("bcd_a", n_bcd_a, 16'(h[0] * 256 + t[0] * 16 + o[0]));
    check("bcd_b", n_bcd_b, 16'(h[1] * 256 + t[1] * 16 + o[1]));
    check("bl_bcd_a", b_bcd_a, 16'(h[0] * 256 + t[0] * 16 + o[0]));
    check("seg_a_h", n_seg_a_h, seg_tab[h[0]]);
    check("seg_a_t", n_seg_a_t, seg_tab[t[0]]);
    check("seg_a_o", n_seg_a_o, seg_tab[o[0]]);
    check("seg_b_h", n_seg_b_h, seg_tab[h[1]]);
    check("seg_b_t", n_seg_b_t, seg_tab[t[1]]);
    check("seg_b_o", n_seg_b_o, seg_tab[o[1]]);
    // Blanking only exists once a result has been written; reset shows digit 0.
    check("bl_seg_a_o", b_seg_a_o, seg_tab[o[0]]);
    check("bl_seg_b_o", b_seg_b_o, seg_tab[o[1]]);
  endtask

  initial begin
    wait (chk_en);
    forever begin
      @(negedge clk);
      compare_all();
    end
  end

  task automatic send(input bit ch, input int v, output int cap_cyc);
    bit got = 0;
    @(negedge clk);
    if (ch) begin req_b = 1; val_b = 16'(v); end
    else    begin req_a = 1; val_a = 16'(v); end
    cap_cyc = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ch ? n_ack_b : n_ack_a) begin got = 1; cap_cyc = cyc; end
    end
    if (ch) req_b = 0; else req_a = 0;
    check("ack_seen", got, 1);
  endtask

  task automatic send_both(input int va, input int vb, output int ca, output int cb);
    bit ga = 0, gb = 0;
    @(negedge clk);
    req_a = 1; val_a = 16'(va); req_b = 1; val_b = 16'(vb);
    ca = -1; cb = -1;
    for (int i = 0; i < 80 && !(ga && gb); i++) begin
      @(negedge clk);
      if (n_ack_a && req_a) begin req_a = 0; ga = 1; ca = cyc; end
      if (n_ack_b && req_b) begin req_b = 0; gb = 1; cb = cyc; end
    end
    req_a = 0; req_b = 0;
    check("both_acks", {ga, gb}, 2'b11);
  endtask

  task automatic wait_done(output int dcyc, output bit dch);
    bit got = 0;
    dcyc = -1; dch = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (n_done) begin got = 1; dcyc = cyc; dch = n_done_ch; end
    end
    check("done_seen", got, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 0;
    @(posedge clk); #2 rst_n = 1;
  endtask

  initial begin
    int ca, cb, dc;
    bit dch;
    rst_n = 0; req_a = 0; req_b = 0; val_a = 0; val_b = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);
    check("rst_busy", n_busy, 0);
    check("rst_bcd_a", n_bcd_a, 0);
    check("rst_seg_a_h", n_seg_a_h, 7'b1000000);
    check("rst_bl_seg_b_t", b_seg_b_t, 7'b1000000);

    // Single conversion on A
    send(0, 437, ca);
    wait_done(dc, dch);
    check("latency_437", 16'(dc - ca), 11);
    check("done_ch_437", dch, 0);
    check("lit_bcd_a_437", n_bcd_a, 12'h437);
    check("lit_seg_a_h_437", n_seg_a_h, 7'b0011001);
    check("lit_seg_a_t_437", n_seg_a_t, 7'b0110000);
    check("lit_seg_a_o_437", n_seg_a_o, 7'b1111000);
    check("lit_bcd_b_437", n_bcd_b, 0);

    // Saturation on B, then an in-range value
    send(1, 1234, ca);
    wait_done(dc, dch);
    check("done_ch_1234", dch, 1);
    check("lit_sat_b", n_sat_b, 1);
    check("lit_bcd_b_999", n_bcd_b, 12'h999);
    check("lit_seg_b_t_999", n_seg_b_t, 7'b0010000);
    send(1, 12, ca);
    wait_done(dc, dch);
    check("lit_sat_b_clr", n_sat_b, 0);
    check("lit_bcd_b_012", n_bcd_b, 12'h012);
    check("lit_bl_seg_b_h_012", b_seg_b_h, 7'b1111111);
    check("lit_bl_seg_b_t_012", b_seg_b_t, 7'b1111001);

    // Arbitration: A favoured after reset, then B after an A-only conversion
    do_reset();
    send_both(100, 250, ca, cb);
    check("arb1_gap", 16'(cb - ca), 12);
    wait_done(dc, dch);
    check("arb1_done_ch", dch, 1);
    check("lit_bcd_a_100", n_bcd_a, 12'h100);
    check("lit_bcd_b_250", n_bcd_b, 12'h250);
    send(0, 7, ca);
    wait_done(dc, dch);
    send_both(300, 45, ca, cb);
    check("arb2_gap", 16'(ca - cb), 12);
    wait_done(dc, dch);
    check("arb2_done_ch", dch, 0);
    check("lit_bcd_a_300", n_bcd_a, 12'h300);

    // Reset in the middle of a shift sequence
    send(0, 437, ca);
    repeat (5) @(negedge clk);
    @(posedge clk); #2 rst_n = 0;
    repeat (2) @(negedge clk);
    check("midrst_busy", n_busy, 0);
    check("midrst_bcd_a", n_bcd_a, 0);
    check("midrst_seg_a_h", n_seg_a_h, 7'b1000000);
    @(posedge clk); #2 rst_n = 1;
    repeat (14) @(negedge clk);
    check("midrst_no_done_bcd", n_bcd_a, 0);
    send(0, 8, ca);
    wait_done(dc, dch);
    check("lit_bcd_a_008", n_bcd_a, 12'h008);

    // Leading-zero blanking
    send(0, 5, ca);
    wait_done(dc, dch);
    check("bl5_h", b_seg_a_h, 7'b1111111);
    check("bl5_t", b_seg_a_t, 7'b1111111);
    check("bl5_o", b_seg_a_o, 7'b0010010);
    check("nobl5_h", n_seg_a_h, 7'b1000000);
    send(0, 0, ca);
    wait_done(dc, dch);
    check("bl0_h", b_seg_a_h, 7'b1111111);
    check("bl0_t", b_seg_a_t, 7'b1111111);
    check("bl0_o", b_seg_a_o, 7'b1000000);
    send(0, 40, ca);
    wait_done(dc, dch);
    check("bl40_h", b_seg_a_h, 7'b1111111);
    check("bl40_t", b_seg_a_t, 7'b0011001);
    check("bl40_o", b_seg_a_o, 7'b1000000);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
